// File: rtl/led_count_sequencer_pkg.sv
// Shared types and build constants for the LED count sequencer.
package led_count_sequencer_pkg;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Board builds use the long intervals; simulation builds shrink them.
  localparam int unsigned TICK_DIV_HW    = 50_000_000;
  localparam int unsigned DEB_CYCLES_HW  = 1_000_000;
  localparam int unsigned TICK_DIV_SIM   = 5;
  localparam int unsigned DEB_CYCLES_SIM = 4;

endpackage

// File: rtl/led_count_sequencer_btn_conditioner.sv
// Raw button to single-cycle press pulse: 2-FF sync, debounce filter, rising-edge detect.
module btn_conditioner
  import led_count_sequencer_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_HW
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;
  logic          prev_q;
  logic          press_q, press_d;

  // Filtered level only moves after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    cnt_d   = cnt_q;
    filt_d  = filt_q;
    press_d = filt_q & ~prev_q;
    if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      filt_d = sync2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      filt_q  <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
      prev_q  <= filt_q;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/led_count_sequencer.sv
// Button-driven LED counter: run/stop FSM, tick prescaler and up/down counter, single clock.
module led_count_sequencer
  import led_count_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV   = TICK_DIV_HW,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_HW,
  parameter int unsigned WIDTH      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             btn_dir,
  input  logic             btn_clr,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             dir_up,
  output logic             tick,
  output logic             wrap
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};

  logic run_p, step_p, dir_p, clr_p;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_run  (.clk(clk), .reset(reset), .btn_raw(btn_run),  .press(run_p));
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_step (.clk(clk), .reset(reset), .btn_raw(btn_step), .press(step_p));
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_dir  (.clk(clk), .reset(reset), .btn_raw(btn_dir),  .press(dir_p));
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_clr  (.clk(clk), .reset(reset), .btn_raw(btn_clr),  .press(clr_p));

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_up_q, dir_up_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             upd;

  // tick_q is high exactly while the prescaler sits at its last value; the count moves on the following edge.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    count_d  = count_q;
    dir_up_d = dir_up_q ^ dir_p;
    wrap_d   = 1'b0;
    tick_d   = 1'b0;
    upd      = 1'b0;

    if (run_p) begin
      state_d = (state_q == RUNNING) ? STOPPED : RUNNING;
    end

    if (clr_p || run_p || (state_q != RUNNING)) begin
      presc_d = '0;
    end else if (presc_q == PRESC_MAX) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
    tick_d = (state_d == RUNNING) && (presc_d == PRESC_MAX);

    // Step is judged against the pre-toggle state; clear overrides any update.
    upd = !clr_p && (((state_q == RUNNING) && tick_q) || ((state_q == STOPPED) && step_p));

    if (clr_p) begin
      count_d = '0;
    end else if (upd) begin
      if (dir_up_q == DIR_UP) begin
        count_d = count_q + WIDTH'(1);
        wrap_d  = (count_q == CNT_MAX);
      end else begin
        count_d = count_q - WIDTH'(1);
        wrap_d  = (count_q == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= STOPPED;
      presc_q  <= '0;
      count_q  <= '0;
      dir_up_q <= DIR_UP;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      count_q  <= count_d;
      dir_up_q <= dir_up_d;
      tick_q   <= tick_d;
      wrap_q   <= wrap_d;
    end
  end

  assign count   = count_q;
  assign running = (state_q == RUNNING);
  assign dir_up  = dir_up_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_led_count_sequencer.sv
// Directed bench for led_count_sequencer with TICK_DIV=5, DEB_CYCLES=4.
module tb_led_count_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_run, btn_step, btn_dir, btn_clr;
  logic [3:0] count;
  logic       running, dir_up, tick, wrap;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [3:0] step_exp [3] = '{4'd15, 4'd14, 4'd13};

  always #5 clk = ~clk;

  led_count_sequencer #(.TICK_DIV(5), .DEB_CYCLES(4), .WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .btn_run(btn_run), .btn_step(btn_step), .btn_dir(btn_dir), .btn_clr(btn_clr),
    .count(count), .running(running), .dir_up(dir_up), .tick(tick), .wrap(wrap)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step(1);
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: btn_run  = v;
      1: btn_step = v;
      2: btn_dir  = v;
      default: btn_clr = v;
    endcase
  endtask

  // Raise, wait until the press has taken effect, release.
  task automatic press(input int idx);
    set_btn(idx, 1'b1);
    step(8);
    set_btn(idx, 1'b0);
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (dir_up !== 1'b1) begin n_fail++; $display("FAIL reset_dir got %0b want 1", dir_up); end
    n_checks++; if ({running, tick, wrap} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {running, tick, wrap}); end
    step(3);
    reset = 1'b0;
    step(2);
    n_checks++; if ({count, running, dir_up, tick, wrap} !== 8'b0000_0100) begin
      n_fail++; $display("FAIL post_reset_idle got %b want 00000100", {count, running, dir_up, tick, wrap});
    end
  endtask

  task automatic test_stopped_dir_step();
    press(2);
    n_checks++; if (dir_up !== 1'b0) begin n_fail++; $display("FAIL dir_toggle got %0b want 0", dir_up); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL dir_no_count got %0d want 0", count); end
    step(6);
    for (int i = 0; i < 3; i++) begin
      press(1);
      n_checks++; if (count !== step_exp[i]) begin n_fail++; $display("FAIL step_down[%0d] got %0d want %0d", i, count, step_exp[i]); end
      n_checks++; if (wrap !== (i == 0)) begin n_fail++; $display("FAIL step_wrap[%0d] got %0b want %0b", i, wrap, (i == 0)); end
      n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL step_tick[%0d] got %0b want 0", i, tick); end
      step(6);
    end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_one_cycle got %0b want 0", wrap); end
  endtask

  task automatic test_glitch();
    btn_step = 1'b1;
    step(3);
    btn_step = 1'b0;
    step(12);
    n_checks++; if (count !== 4'd13) begin n_fail++; $display("FAIL glitch_3cyc got %0d want 13", count); end
    press(2);
    n_checks++; if (dir_up !== 1'b1) begin n_fail++; $display("FAIL dir_back_up got %0b want 1", dir_up); end
    step(6);
    btn_step = 1'b1;
    step(4);
    btn_step = 1'b0;
    step(10);
    n_checks++; if (count !== 4'd14) begin n_fail++; $display("FAIL glitch_4cyc got %0d want 14", count); end
    step(10);
    n_checks++; if (count !== 4'd14) begin n_fail++; $display("FAIL glitch_single got %0d want 14", count); end
  endtask

  task automatic test_clear_stopped();
    press(3);
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL clr_stopped got %0d want 0", count); end
    n_checks++; if ({running, dir_up} !== 2'b01) begin n_fail++; $display("FAIL clr_keeps_state got %b want 01", {running, dir_up}); end
    step(6);
  endtask

  task automatic test_run_wrap();
    logic [3:0] exp_cnt;
    btn_run = 1'b1;
    step(7);
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL run_early got %0b want 0", running); end
    step(1);
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL run_latency got %0b want 1", running); end
    btn_run = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 80; c++) begin
      step(1);
      exp_cnt = 4'((c / 5) % 16);
      n_checks++; if (tick !== (c % 5 == 4)) begin n_fail++; $display("FAIL run_tick c=%0d got %0b want %0b", c, tick, (c % 5 == 4)); end
      n_checks++; if (count !== exp_cnt) begin n_fail++; $display("FAIL run_count c=%0d got %0d want %0d", c, count, exp_cnt); end
      n_checks++; if (wrap !== (c == 80)) begin n_fail++; $display("FAIL run_wrap c=%0d got %0b want %0b", c, wrap, (c == 80)); end
    end
  endtask

  task automatic test_clr_tick();
    step_to(112);
    btn_clr = 1'b1;
    step_to(119);
    n_checks++; if ({tick, count} !== 5'b1_0111) begin n_fail++; $display("FAIL clr_pre got tick,count=%b want 10111", {tick, count}); end
    btn_clr = 1'b0;
    step(1);
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL clr_tick_count got %0d want 0", count); end
    n_checks++; if ({wrap, running} !== 2'b01) begin n_fail++; $display("FAIL clr_tick_flags got %b want 01", {wrap, running}); end
    step_to(123);
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL clr_tick_early got %0b want 0", tick); end
    step(1);
    n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL clr_next_tick got %0b want 1", tick); end
    step(1);
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL clr_resume got %0d want 1", count); end
  endtask

  task automatic test_dir_tick();
    step_to(132);
    btn_dir = 1'b1;
    step_to(139);
    n_checks++; if ({tick, count, dir_up} !== 6'b1_0011_1) begin n_fail++; $display("FAIL dir_tick_pre got %b want 100111", {tick, count, dir_up}); end
    btn_dir = 1'b0;
    step(1);
    n_checks++; if (count !== 4'd4) begin n_fail++; $display("FAIL dir_old_dir got %0d want 4", count); end
    n_checks++; if (dir_up !== 1'b0) begin n_fail++; $display("FAIL dir_tick_toggle got %0b want 0", dir_up); end
    step_to(145);
    n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL dir_new_dir got %0d want 3", count); end
  endtask

  task automatic test_reset_midrun();
    int budget = 100;
    while (count !== 4'd9 && budget > 0) begin
      step(1);
      budget--;
    end
    n_checks++; if (count !== 4'd9) begin n_fail++; $display("FAIL wait_count9 got %0d want 9 (timeout)", count); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL midrun_reset_count got %0d want 0", count); end
    n_checks++; if ({running, dir_up, tick, wrap} !== 4'b0100) begin n_fail++; $display("FAIL midrun_reset_flags got %b want 0100", {running, dir_up, tick, wrap}); end
    step(2);
    reset = 1'b0;
    step(2);
    press(1);
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL after_reset_step1 got %0d want 1", count); end
    step(6);
    press(1);
    n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL after_reset_step2 got %0d want 2", count); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL after_reset_stopped got %0b want 0", running); end
  endtask

  initial begin
    reset    = 1'b1;
    btn_run  = 1'b0;
    btn_step = 1'b0;
    btn_dir  = 1'b0;
    btn_clr  = 1'b0;
    test_reset();
    test_stopped_dir_step();
    test_glitch();
    test_clear_stopped();
    test_run_wrap();
    test_clr_tick();
    test_dir_tick();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
